muldiv_unit: RTL and testbench

Multi-cycle multiply/divide unit with architectural HI/LO registers. It sits in the Execute stage and responds to the controller's `mdstartE`/`hilosrcE` requests. It returns `mdrunE` so the controller can stall HI/LO accesses and mask HI/LO writes (`hilodisableE`) while an operation is in flight. It implements MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_if.sv | 28 ++
 rtl/muldiv_step.sv | 38 +++
 rtl/muldiv_unit.sv | 127 ++++++++++++
 tb/tb_muldiv_unit.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
// The optional single-cycle multiplier is enabled with MULDIV_FAST_MULT_EN (see muldiv_unit).
package muldiv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } md_state_e;

   localparam int          MD_ITERS  = 32;
   localparam int          CNT_W     = $clog2(MD_ITERS);
   localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

   // Magnitude of an operand when treated as signed, raw value otherwise.
   function automatic logic [31:0] abs_if(input logic sgn, input logic [31:0] v);
      return (sgn && v[31]) ? -v : v;
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Controller <-> multiply/divide unit request and HI/LO read bus.
// The controller drives through the master modport; muldiv_unit uses slave.
interface muldiv_if;

   logic        mdstartE;
   logic        mddivE;
   logic        mdsignedE;
   logic [31:0] srcaE;
   logic [31:0] srcbE;
   logic        hilowriteE;
   logic        hilosrcE;
   logic        hiloselE;
   logic        mdrunE;
   logic [31:0] hiloutE;

   modport master (
      output mdstartE, mddivE, mdsignedE, srcaE, srcbE,
             hilowriteE, hilosrcE, hiloselE,
      input  mdrunE, hiloutE
   );

   modport slave (
      input  mdstartE, mddivE, mdsignedE, srcaE, srcbE,
             hilowriteE, hilosrcE, hiloselE,
      output mdrunE, hiloutE
   );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the iterative datapath: a shift-add multiply step or a
// restoring divide step on {hi_acc, lo_acc}, selected by mddiv.
module muldiv_step (
   input  logic        mddiv,
   input  logic [31:0] operand,
   input  logic [31:0] hi_acc,
   input  logic [31:0] lo_acc,
   output logic [31:0] hi_next,
   output logic [31:0] lo_next
);

   logic [32:0] sum;
   logic [32:0] shifted;
   logic [32:0] diff;

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the block can leave a latch behind.
   always_comb begin
      hi_next = hi_acc;
      lo_next = lo_acc;
      sum     = {1'b0, hi_acc} + (lo_acc[0] ? {1'b0, operand} : 33'd0);
      shifted = {hi_acc, lo_acc[31]};
      diff    = shifted - {1'b0, operand};
      if (mddiv) begin
         // A clear borrow bit means the divisor fits: keep the difference.
         if (!diff[32]) begin
            hi_next = diff[31:0];
            lo_next = {lo_acc[30:0], 1'b1};
         end else begin
            hi_next = shifted[31:0];
            lo_next = {lo_acc[30:0], 1'b0};
         end
      end else begin
         {hi_next, lo_next} = {sum, lo_acc[31:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Define MULDIV_FAST_MULT_EN to finish multiplies in one cycle with a 64-bit '*'.
module muldiv_unit
   import muldiv_pkg::*;
(
   input logic    clk,
   input logic    reset,
   muldiv_if.slave md
);

   md_state_e        state, state_next;
   logic [CNT_W-1:0] count;
   logic [31:0]      hi, lo;
   logic [31:0]      hi_acc, lo_acc, operand;
   logic [31:0]      step_hi, step_lo;
   logic             md_div, neg_q, neg_r, div0;
   logic             mdrun;
   logic [31:0]      op_a, op_b;
   logic [63:0]      prod_fix;
   logic [31:0]      fix_hi, fix_lo;
   logic [63:0]      result;

   assign op_a = abs_if(md.mdsignedE, md.srcaE);
   assign op_b = abs_if(md.mdsignedE, md.srcbE);

`ifdef MULDIV_FAST_MULT_EN
   logic signed [63:0] fast_a, fast_b;
   logic        [63:0] fast_prod;
   assign fast_a    = md.mdsignedE ? 64'($signed(md.srcaE)) : {32'd0, md.srcaE};
   assign fast_b    = md.mdsignedE ? 64'($signed(md.srcbE)) : {32'd0, md.srcbE};
   assign fast_prod = fast_a * fast_b;
`endif

   muldiv_step u_step (
      .mddiv   (md_div),
      .operand (operand),
      .hi_acc  (hi_acc),
      .lo_acc  (lo_acc),
      .hi_next (step_hi),
      .lo_next (step_lo)
   );

   always_comb begin : fsm_next
      state_next = state;
      unique case (state)
         IDLE: begin
            if (md.mdstartE) begin
`ifdef MULDIV_FAST_MULT_EN
               state_next = md.mddivE ? RUN : FIX;
`else
               state_next = RUN;
`endif
            end
         end
         RUN:     if (count == '0) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Divide by zero: the accumulated remainder is |srcaE|, so restoring the
   // dividend sign hands back the original srcaE.
   always_comb begin : sign_fix
      prod_fix = neg_q ? -{hi_acc, lo_acc} : {hi_acc, lo_acc};
      fix_hi   = neg_r ? -hi_acc : hi_acc;
      fix_lo   = div0 ? DIV0_QUOT : (neg_q ? -lo_acc : lo_acc);
      result   = md_div ? {fix_hi, fix_lo} : prod_fix;
   end

   // NOTE: sequential state is assigned with <= only, so every register sees
   // the pre-edge values of the others regardless of statement order.
   always_ff @(posedge clk) begin
      // NOTE: the unit holds no memories, so every register (HI/LO included)
      // is cleared by reset, which also aborts an operation in flight.
      if (reset) begin
         state   <= IDLE;
         mdrun   <= 1'b0;
         count   <= '0;
         hi      <= '0;
         lo      <= '0;
         hi_acc  <= '0;
         lo_acc  <= '0;
         operand <= '0;
         md_div  <= 1'b0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         div0    <= 1'b0;
      end else begin
         state <= state_next;
         mdrun <= (state_next != IDLE);
         unique case (state)
            IDLE: begin
               if (md.mdstartE) begin
                  md_div  <= md.mddivE;
                  neg_q   <= md.mdsignedE & (md.srcaE[31] ^ md.srcbE[31]);
                  neg_r   <= md.mdsignedE & md.srcaE[31];
                  div0    <= md.mddivE & (md.srcbE == '0);
                  count   <= CNT_W'(MD_ITERS - 1);
                  hi_acc  <= '0;
                  lo_acc  <= md.mddivE ? op_a : op_b;
                  operand <= md.mddivE ? op_b : op_a;
`ifdef MULDIV_FAST_MULT_EN
                  if (!md.mddivE) begin
                     {hi_acc, lo_acc} <= fast_prod;
                     neg_q            <= 1'b0;
                  end
`endif
               end else if (md.hilowriteE) begin
                  if (md.hilosrcE) hi <= md.srcaE;
                  else             lo <= md.srcaE;
               end
            end
            RUN: begin
               hi_acc <= step_hi;
               lo_acc <= step_lo;
               count  <= count - 1'b1;
            end
            FIX:     {hi, lo} <= result;
            default: ;
         endcase
      end
   end

   assign md.mdrunE  = mdrun;
   assign md.hiloutE = md.hiloselE ? hi : lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a latency/arithmetic reference model
// checked every cycle, plus hand-computed HI/LO and busy-length expectations.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MULT_EN
   localparam int MULT_LAT = 1;
`else
   localparam int MULT_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;

   muldiv_if md_bus ();

   muldiv_unit dut (
      .clk   (clk),
      .reset (reset),
      .md    (md_bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
      end
   endtask

   // Architectural reference: a busy countdown plus the arithmetic result.
   int          m_left  = 0;
   logic [31:0] m_hi    = '0;
   logic [31:0] m_lo    = '0;
   logic [31:0] p_hi    = '0;
   logic [31:0] p_lo    = '0;
   bit          m_valid = 1'b0;

   function automatic logic [63:0] ref_result(input bit div, input bit sgn,
                                              input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
      sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
      if (!div) begin
         p = 64'(sa * sb);
         return p;
      end
      if (b == '0) return {a, 32'hFFFF_FFFF};
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_left  = 0;
         m_hi    = '0;
         m_lo    = '0;
         m_valid = 1'b1;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            m_hi = p_hi;
            m_lo = p_lo;
         end
      end else if (md_bus.mdstartE) begin
         {p_hi, p_lo} = ref_result(md_bus.mddivE, md_bus.mdsignedE, md_bus.srcaE, md_bus.srcbE);
         m_left = md_bus.mddivE ? DIV_LAT : MULT_LAT;
      end else if (md_bus.hilowriteE) begin
         if (md_bus.hilosrcE) m_hi = md_bus.srcaE;
         else                 m_lo = md_bus.srcaE;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("mdrunE", {31'd0, md_bus.mdrunE}, {31'd0, (m_left > 0)});
         check("hiloutE", md_bus.hiloutE, md_bus.hiloselE ? m_hi : m_lo);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic read_hilo(input string name, input logic [31:0] want_hi, input logic [31:0] want_lo);
      md_bus.hiloselE = 1'b1;
      #1 check({name, " HI"}, md_bus.hiloutE, want_hi);
      md_bus.hiloselE = 1'b0;
      #1 check({name, " LO"}, md_bus.hiloutE, want_lo);
   endtask

   task automatic run_op(input string name, input bit div, input bit sgn,
                         input logic [31:0] a, input logic [31:0] b, input bit wr,
                         input int lat, input logic [31:0] want_hi, input logic [31:0] want_lo);
      int n;
      md_bus.mddivE     = div;
      md_bus.mdsignedE  = sgn;
      md_bus.srcaE      = a;
      md_bus.srcbE      = b;
      md_bus.hilowriteE = wr;
      md_bus.hilosrcE   = 1'b1;
      md_bus.mdstartE   = 1'b1;
      tick();
      md_bus.mdstartE   = 1'b0;
      md_bus.hilowriteE = 1'b0;
      n = 0;
      while (md_bus.mdrunE === 1'b1 && n < 200) begin
         n++;
         tick();
      end
      check({name, " busy"}, 32'(n), 32'(lat));
      read_hilo(name, want_hi, want_lo);
   endtask

   task automatic write_hilo(input bit to_hi, input logic [31:0] data);
      md_bus.hilosrcE   = to_hi;
      md_bus.srcaE      = data;
      md_bus.hilowriteE = 1'b1;
      tick();
      md_bus.hilowriteE = 1'b0;
   endtask

   initial begin
      int n;
      md_bus.mdstartE   = 1'b0;
      md_bus.mddivE     = 1'b0;
      md_bus.mdsignedE  = 1'b0;
      md_bus.srcaE      = '0;
      md_bus.srcbE      = '0;
      md_bus.hilowriteE = 1'b0;
      md_bus.hilosrcE   = 1'b0;
      md_bus.hiloselE   = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      check("reset mdrunE", {31'd0, md_bus.mdrunE}, 32'd0);
      read_hilo("reset", 32'h0, 32'h0);

      run_op("mult s",       1'b0, 1'b1, 32'hFFFF_FFFE, 32'h3,         1'b0, MULT_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_op("multu",        1'b0, 1'b0, 32'hFFFF_FFFE, 32'h3,         1'b0, MULT_LAT, 32'h0000_0002, 32'hFFFF_FFFA);
      run_op("div -7/2",     1'b1, 1'b1, 32'hFFFF_FFF9, 32'h2,         1'b0, DIV_LAT,  32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu 100/7",   1'b1, 1'b0, 32'd100,       32'd7,         1'b0, DIV_LAT,  32'd2,         32'd14);
      run_op("div 5/0",      1'b1, 1'b1, 32'd5,         32'd0,         1'b0, DIV_LAT,  32'd5,         32'hFFFF_FFFF);
      run_op("div ovf",      1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, DIV_LAT,  32'h0,         32'h8000_0000);
      run_op("div -7/0",     1'b1, 1'b1, 32'hFFFF_FFF9, 32'd0,         1'b0, DIV_LAT,  32'hFFFF_FFF9, 32'hFFFF_FFFF);
      run_op("div 7/-2",     1'b1, 1'b1, 32'd7,         32'hFFFF_FFFE, 1'b0, DIV_LAT,  32'd1,         32'hFFFF_FFFD);
      run_op("mult min*min", 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, MULT_LAT, 32'h4000_0000, 32'h0);
      run_op("multu max",    1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, MULT_LAT, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("divu max/1",   1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1,         1'b0, DIV_LAT,  32'h0,         32'hFFFF_FFFF);
      run_op("mult 3*4",     1'b0, 1'b1, 32'd3,         32'd4,         1'b0, MULT_LAT, 32'h0,         32'd12);

      // MTLO/MTHI, then a second start and an MTHI while a divide is running.
      write_hilo(1'b0, 32'h1234_5678);
      write_hilo(1'b1, 32'hCAFE_F00D);
      read_hilo("mt", 32'hCAFE_F00D, 32'h1234_5678);
      md_bus.mddivE    = 1'b1;
      md_bus.mdsignedE = 1'b0;
      md_bus.srcaE     = 32'd100;
      md_bus.srcbE     = 32'd7;
      md_bus.mdstartE  = 1'b1;
      tick();
      md_bus.mdstartE  = 1'b0;
      n = 0;
      while (md_bus.mdrunE === 1'b1 && n < 200) begin
         n++;
         if (n == 4) begin
            md_bus.mddivE     = 1'b0;
            md_bus.srcaE      = 32'hDEAD_BEEF;
            md_bus.srcbE      = 32'd3;
            md_bus.mdstartE   = 1'b1;
            md_bus.hilowriteE = 1'b1;
            md_bus.hilosrcE   = 1'b1;
         end
         tick();
         if (n == 4) begin
            md_bus.mdstartE   = 1'b0;
            md_bus.hilowriteE = 1'b0;
            read_hilo("run held", 32'hCAFE_F00D, 32'h1234_5678);
         end
      end
      check("ignored busy", 32'(n), 32'd33);
      read_hilo("ignored", 32'd2, 32'd14);

      // Start and MTHI together in IDLE: the start wins.
      run_op("start+mthi", 1'b1, 1'b0, 32'd100, 32'd7, 1'b1, DIV_LAT, 32'd2, 32'd14);

      // Reset in the middle of RUN aborts and clears HI/LO.
      md_bus.mddivE    = 1'b1;
      md_bus.mdsignedE = 1'b1;
      md_bus.srcaE     = 32'hFFFF_FFF9;
      md_bus.srcbE     = 32'd2;
      md_bus.mdstartE  = 1'b1;
      tick();
      md_bus.mdstartE  = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check("pre-abort mdrunE", {31'd0, md_bus.mdrunE}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort mdrunE", {31'd0, md_bus.mdrunE}, 32'd0);
      read_hilo("abort", 32'h0, 32'h0);
      run_op("after abort", 1'b1, 1'b0, 32'd100, 32'd7, 1'b0, DIV_LAT, 32'd2, 32'd14);

      tick();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
